// File: rtl/vdp_bus_port.sv
// vdp_bus_port: CPU register port of the VDP, mapped at FFF0-FFFF (offset 0-F).
// Holds control registers R0-R7, the VRAM pointer with auto-increment, a data
// port backed by a write FIFO plus a read prefetch, and a status register.
// Drives a req/ack master into the VRAM arbiter.
// Build option: define VDP_IRQ_EN to drive irq from the vblank flag gated by
// R1[5]; without it irq is tied low.
//
// state | meaning
// IDLE  | no VRAM access outstanding
// WR    | FIFO head presented as a VRAM write, waiting for ack
// RD    | prefetch read presented to VRAM, waiting for ack
module vdp_bus_port #(
  parameter int FIFO_DEPTH      = 4,
  parameter int VRAM_ADDR_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       chipSelect,
  input  logic                       writeEnable,
  input  logic [3:0]                 address,
  input  logic [7:0]                 dataIn,
  output logic [7:0]                 dataOut,
  input  logic                       vblankPulse,
  output logic                       vramReq,
  output logic                       vramWrite,
  output logic [VRAM_ADDR_WIDTH-1:0] vramAddress,
  output logic [7:0]                 vramWriteData,
  input  logic [7:0]                 vramReadData,
  input  logic                       vramAck,
  output logic [63:0]                ctrl,
  output logic                       irq
);

  localparam int AW = VRAM_ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [63:0]     r_ctrl;
  logic [AW-1:0]   r_ptr;
  logic [7:0]      r_data_out;
  logic [7:0]      r_prefetch;
  logic            r_pending;
  logic            r_rearm;
  logic [AW-1:0]   r_pend_addr;
  logic [AW-1:0]   r_rd_addr;
  logic            r_vblank;
  logic            r_overflow;

  logic [AW-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [7:0]      r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_idx;
  logic [PW-1:0]   r_rd_idx;
  logic [CW-1:0]   r_count;

  logic            w_wr;
  logic            w_rd;
  logic            w_data_wr;
  logic            w_data_rd;
  logic            w_ptr_wr;
  logic            w_stat_rd;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_rd_done;
  logic            w_arm;
  logic            w_vblank_next;
  logic [AW-1:0]   w_step;
  logic [AW-1:0]   w_ptr_next;
  logic [7:0]      w_status;
  logic [7:0]      w_rd_data;

  assign w_wr      = chipSelect & writeEnable;
  assign w_rd      = chipSelect & ~writeEnable;
  assign w_data_wr = w_wr && (address == 4'hA);
  assign w_data_rd = w_rd && (address == 4'hA);
  assign w_ptr_wr  = w_wr && ((address == 4'h8) || (address == 4'h9));
  assign w_stat_rd = w_rd && (address == 4'hB);

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = (r_state == S_WR) && vramAck;
  assign w_rd_done = (r_state == S_RD) && vramAck;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push    = w_data_wr && (!w_full || w_pop);
  assign w_arm     = w_ptr_wr || w_data_rd;

  // Set wins over the clear from a coincident status read.
  assign w_vblank_next = vblankPulse | (r_vblank & ~w_stat_rd);

  assign w_status = {r_vblank, w_full, w_empty, r_pending, 3'b000, r_overflow};
  assign ctrl     = r_ctrl;
  assign dataOut  = r_data_out;

  // Pointer step from R0[1:0]
  always_comb begin
    w_step = '0;
    unique case (r_ctrl[1:0])
      2'b00:   w_step = AW'(1);
      2'b01:   w_step = AW'(2);
      2'b10:   w_step = AW'(32);
      default: w_step = '0;
    endcase
  end

  // Next pointer value: byte writes or auto-increment on data port access
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_wr && (address == 4'h8))
      w_ptr_next = {r_ptr[AW-1:8], dataIn};
    else if (w_wr && (address == 4'h9))
      w_ptr_next = {dataIn[AW-9:0], r_ptr[7:0]};
    else if (w_push || w_data_rd)
      w_ptr_next = r_ptr + w_step;
  end

  // CPU read mux
  always_comb begin
    w_rd_data = '0;
    if (!address[3]) begin
      w_rd_data = r_ctrl[{address[2:0], 3'b000} +: 8];
    end else begin
      unique case (address[2:0])
        3'd0:    w_rd_data = r_ptr[7:0];
        3'd1:    w_rd_data = 8'(r_ptr[AW-1:8]);
        3'd2:    w_rd_data = r_prefetch;
        3'd3:    w_rd_data = w_status;
        default: w_rd_data = '0;
      endcase
    end
  end

  // Control registers, pointer and registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl     <= '0;
      r_ptr      <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr && !address[3])
        r_ctrl[{address[2:0], 3'b000} +: 8] <= dataIn;
      r_ptr <= w_ptr_next;
      if (w_rd)
        r_data_out <= w_rd_data;
    end
  end

  // Status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vblank   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_vblank <= w_vblank_next;
      if (w_data_wr && w_full && !w_pop)
        r_overflow <= 1'b1;
      else if (w_stat_rd)
        r_overflow <= 1'b0;
    end
  end

  // FIFO storage, no reset needed: contents are only consumed when counted valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_idx] <= r_ptr;
      r_fifo_data[r_wr_idx] <= dataIn;
    end
  end

  // FIFO indices and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_idx <= r_wr_idx + PW'(1);
      if (w_pop)  r_rd_idx <= r_rd_idx + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Prefetch tracking: the latest arm wins; an arm during RD keeps pending set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prefetch  <= '0;
      r_pending   <= 1'b0;
      r_rearm     <= 1'b0;
      r_pend_addr <= '0;
      r_rd_addr   <= '0;
    end else begin
      if (w_arm)
        r_pend_addr <= w_ptr_next;
      if (w_arm)
        r_pending <= 1'b1;
      else if (w_rd_done)
        r_pending <= r_rearm;
      if (w_rd_done)
        r_rearm <= 1'b0;
      else if (w_arm && ((r_state == S_RD) || (w_state_next == S_RD)))
        r_rearm <= 1'b1;
      else if (r_state == S_IDLE)
        r_rearm <= 1'b0;
      if ((r_state == S_IDLE) && (w_state_next == S_RD))
        r_rd_addr <= r_pend_addr;
      if (w_rd_done)
        r_prefetch <= vramReadData;
    end
  end

  // VRAM FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // VRAM FSM next state and request outputs; writes take priority over prefetch
  always_comb begin
    w_state_next  = r_state;
    vramReq       = 1'b0;
    vramWrite     = 1'b0;
    vramAddress   = r_fifo_addr[r_rd_idx];
    vramWriteData = r_fifo_data[r_rd_idx];
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty)       w_state_next = S_WR;
        else if (r_pending) w_state_next = S_RD;
      end
      S_WR: begin
        vramReq   = 1'b1;
        vramWrite = 1'b1;
        if (vramAck) w_state_next = S_IDLE;
      end
      S_RD: begin
        vramReq     = 1'b1;
        vramAddress = r_rd_addr;
        if (vramAck) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef VDP_IRQ_EN
  logic r_irq;

  // Interrupt follows the next flag value so it drops right after a status read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= w_vblank_next & r_ctrl[13];
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_bus_port.sv
// Bench for vdp_bus_port: register table, then hand sequences for reset,
// auto-increment, overflow, read ordering and vblank. A VRAM responder acks
// requests and checks each VRAM write against the expected-write queue.
module tb_vdp_bus_port;

  localparam int AW = 14;

`ifdef VDP_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          chipSelect;
  logic          writeEnable;
  logic [3:0]    address;
  logic [7:0]    dataIn;
  logic [7:0]    dataOut;
  logic          vblankPulse;
  logic          vramReq;
  logic          vramWrite;
  logic [AW-1:0] vramAddress;
  logic [7:0]    vramWriteData;
  logic [7:0]    vramReadData;
  logic          vramAck;
  logic [63:0]   ctrl;
  logic          irq;

  always #5 clk = ~clk;

  vdp_bus_port #(.FIFO_DEPTH(4), .VRAM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .chipSelect(chipSelect), .writeEnable(writeEnable),
    .address(address), .dataIn(dataIn), .dataOut(dataOut), .vblankPulse(vblankPulse),
    .vramReq(vramReq), .vramWrite(vramWrite), .vramAddress(vramAddress),
    .vramWriteData(vramWriteData), .vramReadData(vramReadData), .vramAck(vramAck),
    .ctrl(ctrl), .irq(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [21:0]   exp_wr [$];
  logic [7:0]    vmem [0:16383];
  logic          ack_en    = 1'b0;
  logic          chk_order = 1'b0;
  logic [AW-1:0] tb_ptr    = '0;
  logic [1:0]    tb_inc    = 2'b00;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // VRAM responder and write scoreboard
  initial begin
    logic [21:0] e;
    vramAck      = 1'b0;
    vramReadData = '0;
    for (int i = 0; i < 16384; i++) vmem[i] = '0;
    forever begin
      @(negedge clk);
      if (vramAck) begin
        vramAck = 1'b0;
      end else if (vramReq && ack_en && reset) begin
        if (vramWrite) begin
          if (exp_wr.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_vram_write: got addr 0x%04h data 0x%02h, expected none",
                     vramAddress, vramWriteData);
          end else begin
            e = exp_wr.pop_front();
            check64("vram_write", 64'({vramAddress, vramWriteData}), 64'(e));
          end
          vmem[vramAddress] = vramWriteData;
        end else begin
          if (chk_order) check64("write_before_read", 64'(exp_wr.size()), 64'd0);
          vramReadData = vmem[vramAddress];
        end
        vramAck = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] step_of(input logic [1:0] inc);
    case (inc)
      2'b00:   return AW'(1);
      2'b01:   return AW'(2);
      2'b10:   return AW'(32);
      default: return '0;
    endcase
  endfunction

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    chipSelect = 1'b1; writeEnable = 1'b1; address = a; dataIn = d;
    @(negedge clk);
    chipSelect = 1'b0; writeEnable = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    chipSelect = 1'b1; writeEnable = 1'b0; address = a;
    @(negedge clk);
    chipSelect = 1'b0;
    d = dataOut;
  endtask

  task automatic data_write(input logic [7:0] d);
    exp_wr.push_back({tb_ptr, d});
    tb_ptr = tb_ptr + step_of(tb_inc);
    cpu_write(4'hA, d);
  endtask

  task automatic set_ptr(input logic [AW-1:0] p);
    cpu_write(4'h8, p[7:0]);
    cpu_write(4'h9, {2'b00, p[13:8]});
    tb_ptr = p;
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    for (int i = 0; i < 200 && quiet < 4; i++) begin
      @(negedge clk);
      if (!vramReq && !vramAck) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      n_checks++;
      $display("FAIL wait_quiet: got VRAM busy after 200 cycles, expected idle");
    end
  endtask

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [24];

  initial begin
    logic [7:0] rd;

    vecs[0]  = '{1'b1, 4'h0, 8'hA4, 8'h00};
    vecs[1]  = '{1'b1, 4'h1, 8'h20, 8'h00};
    vecs[2]  = '{1'b1, 4'h2, 8'h5A, 8'h00};
    vecs[3]  = '{1'b1, 4'h3, 8'h33, 8'h00};
    vecs[4]  = '{1'b1, 4'h4, 8'h44, 8'h00};
    vecs[5]  = '{1'b1, 4'h5, 8'h55, 8'h00};
    vecs[6]  = '{1'b1, 4'h6, 8'h66, 8'h00};
    vecs[7]  = '{1'b1, 4'h7, 8'h77, 8'h00};
    vecs[8]  = '{1'b1, 4'hB, 8'hFF, 8'h00};
    vecs[9]  = '{1'b1, 4'hC, 8'hFF, 8'h00};
    vecs[10] = '{1'b1, 4'hD, 8'hFF, 8'h00};
    vecs[11] = '{1'b1, 4'hE, 8'hFF, 8'h00};
    vecs[12] = '{1'b1, 4'hF, 8'hFF, 8'h00};
    vecs[13] = '{1'b0, 4'h0, 8'h00, 8'hA4};
    vecs[14] = '{1'b0, 4'h1, 8'h00, 8'h20};
    vecs[15] = '{1'b0, 4'h2, 8'h00, 8'h5A};
    vecs[16] = '{1'b0, 4'h3, 8'h00, 8'h33};
    vecs[17] = '{1'b0, 4'h7, 8'h00, 8'h77};
    vecs[18] = '{1'b0, 4'hC, 8'h00, 8'h00};
    vecs[19] = '{1'b0, 4'hD, 8'h00, 8'h00};
    vecs[20] = '{1'b0, 4'hE, 8'h00, 8'h00};
    vecs[21] = '{1'b0, 4'hF, 8'h00, 8'h00};
    vecs[22] = '{1'b0, 4'h8, 8'h00, 8'h00};
    vecs[23] = '{1'b0, 4'h9, 8'h00, 8'h00};

    reset = 1'b0; chipSelect = 1'b0; writeEnable = 1'b0; address = '0;
    dataIn = '0; vblankPulse = 1'b0;
    repeat (3) @(negedge clk);
    check8("rst_dataOut", dataOut, 8'h00);
    check8("rst_vramReq", 8'(vramReq), 8'h00);
    check64("rst_ctrl", ctrl, 64'h0);
    check8("rst_irq", 8'(irq), 8'h00);
    reset = 1'b1;
    ack_en = 1'b1;

    // register table
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].we) begin
        cpu_write(vecs[i].addr, vecs[i].din);
      end else begin
        cpu_read(vecs[i].addr, rd);
        check8($sformatf("vec%0d_rd_off%0h", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end
    check64("ctrl_concat", ctrl, 64'h7766_5544_335A_20A4);

    // asynchronous reset in the middle of a run with a request outstanding
    cpu_write(4'h3, 8'h5A);
    ack_en = 1'b0;
    cpu_write(4'hA, 8'h99);
    repeat (3) @(negedge clk);
    check8("req_before_reset", 8'(vramReq), 8'h01);
    cpu_read(4'h3, rd);
    check8("r3_before_reset", rd, 8'h5A);
    #2 reset = 1'b0;
    #1;
    check8("async_rst_dataOut", dataOut, 8'h00);
    check64("async_rst_ctrl", ctrl, 64'h0);
    check8("async_rst_vramReq", 8'(vramReq), 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ack_en = 1'b1;
    exp_wr.delete();
    tb_ptr = '0;
    tb_inc = 2'b00;
    cpu_read(4'h3, rd);
    check8("r3_after_reset", rd, 8'h00);
    cpu_read(4'hB, rd);
    check8("status_after_reset", rd, 8'h20);

    // auto-increment by 1 with wrap
    cpu_write(4'h0, 8'h00);
    set_ptr(14'h3FFF);
    wait_quiet();
    data_write(8'h11);
    data_write(8'h22);
    wait_quiet();
    cpu_read(4'h8, rd);
    check8("wrap_ptr_lo", rd, 8'h01);
    cpu_read(4'h9, rd);
    check8("wrap_ptr_hi", rd, 8'h00);

    // increment by 32, then step 0
    cpu_write(4'h0, 8'h02);
    tb_inc = 2'b10;
    set_ptr(14'h0010);
    wait_quiet();
    data_write(8'h33);
    data_write(8'h44);
    wait_quiet();
    cpu_read(4'h8, rd);
    check8("step32_ptr_lo", rd, 8'h50);
    cpu_write(4'h0, 8'h03);
    tb_inc = 2'b11;
    data_write(8'h55);
    wait_quiet();
    cpu_read(4'h8, rd);
    check8("step0_ptr_lo", rd, 8'h50);
    cpu_write(4'h0, 8'h00);
    tb_inc = 2'b00;

    // overflow with acks held off
    set_ptr(14'h0200);
    wait_quiet();
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        exp_wr.push_back({tb_ptr, 8'(8'hC0 + i)});
        tb_ptr = tb_ptr + 14'd1;
      end
      cpu_write(4'hA, 8'(8'hC0 + i));
    end
    repeat (2) @(negedge clk);
    cpu_read(4'hB, rd);
    check8("ovf_status", rd, 8'h41);
    cpu_read(4'hB, rd);
    check8("ovf_cleared", rd, 8'h40);
    ack_en = 1'b1;
    wait_quiet();
    check64("ovf_drained", 64'(exp_wr.size()), 64'd0);
    cpu_read(4'h8, rd);
    check8("ovf_ptr_lo", rd, 8'h04);
    cpu_read(4'hB, rd);
    check8("ovf_status_empty", rd, 8'h20);

    // a prefetch must see an earlier data write
    set_ptr(14'h0100);
    wait_quiet();
    data_write(8'hAB);
    chk_order = 1'b1;
    set_ptr(14'h0100);
    wait_quiet();
    cpu_read(4'hA, rd);
    check8("rd_after_wr", rd, 8'hAB);
    chk_order = 1'b0;
    cpu_read(4'h8, rd);
    check8("rd_ptr_lo", rd, 8'h01);
    wait_quiet();

    // vblank flag, irq, and set-wins on a coincident status read
    cpu_write(4'h1, 8'h20);
    @(negedge clk); vblankPulse = 1'b1;
    @(negedge clk); vblankPulse = 1'b0;
    @(negedge clk);
    check8("irq_on_vblank", 8'(irq), 8'(IRQ_ON));
    cpu_read(4'hB, rd);
    check8("vblank_status", rd, 8'hA0);
    check8("irq_after_status", 8'(irq), 8'h00);
    cpu_read(4'hB, rd);
    check8("vblank_cleared", rd, 8'h20);
    @(negedge clk);
    chipSelect = 1'b1; writeEnable = 1'b0; address = 4'hB; vblankPulse = 1'b1;
    @(negedge clk);
    chipSelect = 1'b0; vblankPulse = 1'b0;
    rd = dataOut;
    check8("coincident_status", rd, 8'h20);
    check8("irq_coincident", 8'(irq), 8'(IRQ_ON));
    cpu_read(4'hB, rd);
    check8("coincident_flag_kept", rd, 8'hA0);
    cpu_read(4'hB, rd);
    check8("coincident_flag_cleared", rd, 8'h20);

    check64("scoreboard_drained", 64'(exp_wr.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
